// File: rtl/ni_pipe_if.sv
// Bundles the stimulus and observation signals of the ni_pipe_harness.
// The master drives the shared and per-copy inputs; the slave is the harness.
interface ni_pipe_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] a2;
    logic [WIDTH-1:0] b;
    logic [1:0]       op;
    logic [WIDTH-1:0] o1;
    logic [WIDTH-1:0] o2;
    logic             out_valid;
    logic             viol;
    logic             prop_ok;
    logic [CNT_W-1:0] fail_cnt;

    modport master (
        output in_valid, a1, a2, b, op,
        input  o1, o2, out_valid, viol, prop_ok, fail_cnt
    );

    modport slave (
        input  in_valid, a1, a2, b, op,
        output o1, o2, out_valid, viol, prop_ok, fail_cnt
    );
endinterface

// File: rtl/ni_pipe_harness.sv
// Self-composition noninterference harness: two pipelined ALU copies plus a sticky
// a1==a2 monitor. Optional macro NI_SHORTCUT_EN ties o2 to copy 1 while untainted.
module ni_alu_pipe #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [1:0]       op_i,
    output logic [WIDTH-1:0] res_o
);
    typedef enum logic [1:0] {
        OP_AND = 2'd0,
        OP_OR  = 2'd1,
        OP_XOR = 2'd2,
        OP_ADD = 2'd3
    } alu_op_e;

    // ADD keeps only the low WIDTH bits; the carry-out is intentionally dropped.
    function automatic logic [WIDTH-1:0] alu_eval(input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input logic [1:0]       op);
        logic [WIDTH-1:0] r;
        case (alu_op_e'(op))
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            default: r = a + b;
        endcase
        return r;
    endfunction

    logic [WIDTH-1:0] res_d;
    logic [WIDTH-1:0] res_q [DEPTH];

    assign res_d = alu_eval(a_i, b_i, op_i);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) res_q[i] <= '0;
        end else begin
            // stage 0: capture on valid, hold through bubbles
            if (in_valid_i) res_q[0] <= res_d;
            // stages 1..DEPTH-1: free-running shift, no stall
            for (int i = 1; i < DEPTH; i++) res_q[i] <= res_q[i-1];
        end
    end

    assign res_o = res_q[DEPTH-1];
endmodule

module ni_pipe_harness #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    ni_pipe_if.slave bus
);
    logic [WIDTH-1:0] res1;
    logic [WIDTH-1:0] res2;
    logic             diff_d;
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] taint_q;
    logic             taint_out;
    logic             viol_d;
    logic             viol_q;
    logic [CNT_W-1:0] fail_cnt_d;
    logic [CNT_W-1:0] fail_cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    ni_alu_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_copy1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (bus.in_valid),
        .a_i        (bus.a1),
        .b_i        (bus.b),
        .op_i       (bus.op),
        .res_o      (res1)
    );

    ni_alu_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_copy2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid_i (bus.in_valid),
        .a_i        (bus.a2),
        .b_i        (bus.b),
        .op_i       (bus.op),
        .res_o      (res2)
    );

    // Only valid samples can break the public-input-equality constraint.
    assign diff_d = bus.in_valid & (bus.a1 != bus.a2);
    assign viol_d = viol_q | diff_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= '0;
            taint_q <= '0;
        end else begin
            // stage 0: valid and taint of the incoming sample
            vld_q[0]   <= bus.in_valid;
            taint_q[0] <= diff_d;
            // stages 1..DEPTH-1: travel with the data
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i]   <= vld_q[i-1];
                taint_q[i] <= taint_q[i-1];
            end
        end
    end

    assign taint_out = taint_q[DEPTH-1];

    assign bus.o1        = res1;
    assign bus.out_valid = vld_q[DEPTH-1];
`ifdef NI_SHORTCUT_EN
    assign bus.o2        = (taint_out | viol_q) ? res2 : res1;
`else
    assign bus.o2        = res2;
`endif

    assign bus.prop_ok = !bus.out_valid | (bus.o1 == bus.o2) | taint_out | viol_q;
    assign fail_cnt_d  = bus.prop_ok ? fail_cnt_q : sat_inc(fail_cnt_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            viol_q     <= 1'b0;
            fail_cnt_q <= '0;
        end else begin
            viol_q     <= viol_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign bus.viol     = viol_q;
    assign bus.fail_cnt = fail_cnt_q;
endmodule

// File: tb/tb_ni_pipe_harness.sv
// Randomised and directed bench for ni_pipe_harness against a history-based
// reference model (outputs derived from the list of samples seen since reset).
module tb_ni_pipe_harness;
    localparam int W = 4;
    localparam int D = 2;
    localparam int C = 8;

    typedef struct {
        bit           v;
        logic [W-1:0] a1;
        logic [W-1:0] a2;
        logic [W-1:0] b;
        logic [1:0]   op;
    } sample_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    sample_t hist[$];

    ni_pipe_if #(.WIDTH(W), .CNT_W(C)) bus ();

    ni_pipe_harness #(.WIDTH(W), .DEPTH(D), .CNT_W(C)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [1:0] op);
        int s;
        case (op)
            2'd0: return a & b;
            2'd1: return a | b;
            2'd2: return a ^ b;
            default: begin
                s = (int'(a) + int'(b)) % (1 << W);
                return s[W-1:0];
            end
        endcase
    endfunction

    // Output after edge m reflects the sample captured DEPTH-1 edges earlier; data
    // registers hold the last valid result through bubbles.
    task automatic model(output bit ev, output logic [W-1:0] e1, output logic [W-1:0] e2,
                         output bit evl);
        int idx;
        bit tout;
        logic [W-1:0] c2;
        idx = hist.size() - D;
        tout = 1'b0;
        ev = 1'b0; e1 = '0; e2 = '0; c2 = '0; evl = 1'b0;
        if (idx >= 0) begin
            ev = hist[idx].v;
            tout = hist[idx].v && (hist[idx].a1 != hist[idx].a2);
            for (int j = idx; j >= 0; j--) begin
                if (hist[j].v) begin
                    e1 = ref_alu(hist[j].a1, hist[j].b, hist[j].op);
                    c2 = ref_alu(hist[j].a2, hist[j].b, hist[j].op);
                    break;
                end
            end
        end
        foreach (hist[k]) if (hist[k].v && hist[k].a1 != hist[k].a2) evl = 1'b1;
`ifdef NI_SHORTCUT_EN
        e2 = (tout || evl) ? c2 : e1;
`else
        e2 = c2;
`endif
    endtask

    task automatic tick(input bit v, input logic [W-1:0] x1, input logic [W-1:0] x2,
                        input logic [W-1:0] y, input logic [1:0] o);
        sample_t s;
        bus.in_valid = v; bus.a1 = x1; bus.a2 = x2; bus.b = y; bus.op = o;
        @(posedge clk);
        s.v = v; s.a1 = x1; s.a2 = x2; s.b = y; s.op = o;
        hist.push_back(s);
        #1;
    endtask

    task automatic do_reset();
        #1 rst_n = 1'b0;
        #2 hist.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #12;
        total++; if (bus.o1 !== 4'h0) begin bad++; $display("FAIL reset_o1 got=%h exp=0", bus.o1); end
        total++; if (bus.o2 !== 4'h0) begin bad++; $display("FAIL reset_o2 got=%h exp=0", bus.o2); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.viol !== 1'b0) begin bad++; $display("FAIL reset_viol got=%b exp=0", bus.viol); end
        total++; if (bus.prop_ok !== 1'b1) begin bad++; $display("FAIL reset_prop_ok got=%b exp=1", bus.prop_ok); end
        total++; if (bus.fail_cnt !== 8'd0) begin bad++; $display("FAIL reset_fail_cnt got=%0d exp=0", bus.fail_cnt); end
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        tick(1'b1, 4'h6, 4'h6, 4'h3, 2'd3);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL add_latency got=%b exp=0", bus.out_valid); end
        tick(1'b0, 4'h0, 4'h0, 4'h0, 2'd0);
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL add_out_valid got=%b exp=1", bus.out_valid); end
        total++; if (bus.o1 !== 4'h9) begin bad++; $display("FAIL add_o1 got=%h exp=9", bus.o1); end
        total++; if (bus.o2 !== 4'h9) begin bad++; $display("FAIL add_o2 got=%h exp=9", bus.o2); end
        total++; if (bus.prop_ok !== 1'b1) begin bad++; $display("FAIL add_prop_ok got=%b exp=1", bus.prop_ok); end
        total++; if (bus.viol !== 1'b0) begin bad++; $display("FAIL add_viol got=%b exp=0", bus.viol); end
    endtask

    task automatic test_add_wrap();
        tick(1'b1, 4'hF, 4'hF, 4'h2, 2'd3);
        tick(1'b0, 4'h0, 4'h0, 4'h0, 2'd0);
        total++; if (bus.o1 !== 4'h1) begin bad++; $display("FAIL wrap_o1 got=%h exp=1", bus.o1); end
        total++; if (bus.o2 !== 4'h1) begin bad++; $display("FAIL wrap_o2 got=%h exp=1", bus.o2); end
        total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL wrap_out_valid got=%b exp=1", bus.out_valid); end
    endtask

    task automatic test_violation();
        do_reset();
        tick(1'b1, 4'h5, 4'hA, 4'hF, 2'd0);
        total++; if (bus.viol !== 1'b1) begin bad++; $display("FAIL viol_set got=%b exp=1", bus.viol); end
        tick(1'b0, 4'h0, 4'h0, 4'h0, 2'd0);
        total++; if (bus.o1 !== 4'h5) begin bad++; $display("FAIL viol_o1 got=%h exp=5", bus.o1); end
        total++; if (bus.o2 !== 4'hA) begin bad++; $display("FAIL viol_o2 got=%h exp=a", bus.o2); end
        total++; if (bus.prop_ok !== 1'b1) begin bad++; $display("FAIL viol_prop_ok got=%b exp=1", bus.prop_ok); end
        total++; if (bus.fail_cnt !== 8'd0) begin bad++; $display("FAIL viol_fail_cnt got=%0d exp=0", bus.fail_cnt); end
        tick(1'b0, 4'h0, 4'h0, 4'h0, 2'd0);
        total++; if (bus.viol !== 1'b1) begin bad++; $display("FAIL viol_sticky got=%b exp=1", bus.viol); end
    endtask

    task automatic test_bubble();
        do_reset();
        tick(1'b0, 4'h1, 4'h2, 4'h0, 2'd0);
        total++; if (bus.viol !== 1'b0) begin bad++; $display("FAIL bubble_viol got=%b exp=0", bus.viol); end
        tick(1'b0, 4'h1, 4'h2, 4'h0, 2'd0);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bubble_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.viol !== 1'b0) begin bad++; $display("FAIL bubble_viol2 got=%b exp=0", bus.viol); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_o [4];
        exp_o[0] = 4'h8; exp_o[1] = 4'hE; exp_o[2] = 4'h6; exp_o[3] = 4'h6;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            if (i < 4) tick(1'b1, 4'hC, 4'hC, 4'hA, 2'(i));
            else       tick(1'b0, 4'h0, 4'h0, 4'h0, 2'd0);
            if (i >= 1) begin
                total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i-1, bus.out_valid); end
                total++; if (bus.o1 !== exp_o[i-1]) begin bad++; $display("FAIL b2b_o1[%0d] got=%h exp=%h", i-1, bus.o1, exp_o[i-1]); end
                total++; if (bus.o2 !== exp_o[i-1]) begin bad++; $display("FAIL b2b_o2[%0d] got=%h exp=%h", i-1, bus.o2, exp_o[i-1]); end
            end
        end
        tick(1'b0, 4'h0, 4'h0, 4'h0, 2'd0);
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL b2b_tail got=%b exp=0", bus.out_valid); end
    endtask

    task automatic test_midflight_reset();
        do_reset();
        tick(1'b1, 4'h3, 4'h3, 4'h4, 2'd3);
        tick(1'b1, 4'h7, 4'h2, 4'h1, 2'd1);
        total++; if (bus.o1 !== 4'h7) begin bad++; $display("FAIL mid_pre_o1 got=%h exp=7", bus.o1); end
        total++; if (bus.viol !== 1'b1) begin bad++; $display("FAIL mid_pre_viol got=%b exp=1", bus.viol); end
        #1 rst_n = 1'b0;
        #1;
        total++; if (bus.o1 !== 4'h0) begin bad++; $display("FAIL mid_o1 got=%h exp=0", bus.o1); end
        total++; if (bus.o2 !== 4'h0) begin bad++; $display("FAIL mid_o2 got=%h exp=0", bus.o2); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b exp=0", bus.out_valid); end
        total++; if (bus.viol !== 1'b0) begin bad++; $display("FAIL mid_viol got=%b exp=0", bus.viol); end
        total++; if (bus.prop_ok !== 1'b1) begin bad++; $display("FAIL mid_prop_ok got=%b exp=1", bus.prop_ok); end
        #1 hist.delete();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 4'h0, 4'h0, 4'h0, 2'd0);
            total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL mid_stale_valid[%0d] got=%b exp=0", i, bus.out_valid); end
            total++; if (bus.o1 !== 4'h0) begin bad++; $display("FAIL mid_stale_o1[%0d] got=%h exp=0", i, bus.o1); end
        end
    endtask

    task automatic test_random();
        bit ev, evl;
        logic [W-1:0] e1, e2, x1, x2;
        do_reset();
        for (int i = 0; i < 300; i++) begin
            if (i == 150) do_reset();
            x1 = W'($urandom);
            x2 = ($urandom_range(0, 7) == 0) ? W'($urandom) : x1;
            tick(1'($urandom_range(0, 3) != 0), x1, x2, W'($urandom), 2'($urandom));
            model(ev, e1, e2, evl);
            total++; if (bus.out_valid !== ev) begin bad++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", i, bus.out_valid, ev); end
            total++; if (bus.o1 !== e1) begin bad++; $display("FAIL rnd_o1[%0d] got=%h exp=%h", i, bus.o1, e1); end
            total++; if (bus.o2 !== e2) begin bad++; $display("FAIL rnd_o2[%0d] got=%h exp=%h", i, bus.o2, e2); end
            total++; if (bus.viol !== evl) begin bad++; $display("FAIL rnd_viol[%0d] got=%b exp=%b", i, bus.viol, evl); end
            total++; if (bus.prop_ok !== 1'b1) begin bad++; $display("FAIL rnd_prop_ok[%0d] got=%b exp=1", i, bus.prop_ok); end
            total++; if (bus.fail_cnt !== 8'd0) begin bad++; $display("FAIL rnd_fail_cnt[%0d] got=%0d exp=0", i, bus.fail_cnt); end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.a1 = '0; bus.a2 = '0; bus.b = '0; bus.op = '0;
        test_reset();
        test_add();
        test_add_wrap();
        test_violation();
        test_bubble();
        test_back_to_back();
        test_midflight_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ni_pipe_harness.md
Name: ni_pipe_harness

Overview:
- Self-composition noninterference harness: two identical copies of a parametrised, pipelined WIDTH-bit ALU are driven with per-copy inputs a1/a2 and shared inputs b/op.
- A sticky monitor encodes the public-input-equality constraint (a1 == a2). Per-stage taint bits align the check with pipeline latency.
- The block reports whether outputs agree whenever the constraint has held for the contributing inputs, and counts failures.
- Generalises the single-bit, one-stage harness to WIDTH, DEPTH and four ALU modes.

Parameters:
- WIDTH, 4, datapath width of a1, a2, b, o1, o2.
- DEPTH, 2, ALU pipeline stages; latency from input to output in cycles (DEPTH >= 1).
- CNT_W, 8, width of the saturating failure counter.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input sample valid (shared by both copies).
- a1  in  WIDTH  copy-1 operand A.
- a2  in  WIDTH  copy-2 operand A.
- b  in  WIDTH  shared operand B.
- op  in  2  shared mode: 0 AND, 1 OR, 2 XOR, 3 ADD.
- o1  out  WIDTH  copy-1 result.
- o2  out  WIDTH  copy-2 result.
- out_valid  out  1  result valid, DEPTH cycles after in_valid.
- viol  out  1  sticky constraint-violation flag.
- prop_ok  out  1  noninterference property holds this cycle.
- fail_cnt  out  CNT_W  saturating count of cycles with prop_ok == 0.

Behaviour:
- Reset (rst_n low, asynchronous): all stage registers, valid bits, taint bits, viol and fail_cnt clear to 0. Consequently o1 = o2 = 0, out_valid = 0, viol = 0 and prop_ok = 1.
- Reset asserted mid-operation flushes all in-flight samples immediately. No output is produced for them after reset is released.
- Stage 0 capture:
  - When in_valid = 1, each copy registers its operands and op, and computes its result in stage 0.
  - ADD is modulo 2^WIDTH; the carry-out is dropped.
  - When in_valid = 0, the stage valid bit is cleared and the data registers hold their values.
- Stages 1..DEPTH-1 shift data, valid and taint forward unconditionally every cycle; there is no stall or backpressure.
- o1, o2 and out_valid are driven from the last stage register.
- Taint: stage-0 taint = in_valid & (a1 != a2). Taint shifts alongside the data; taint_out is the last-stage taint bit.
- viol register:
  - Next value is viol | (in_valid & (a1 != a2)).
  - It is set the cycle after the first violating sample and stays set until reset.
  - Samples with in_valid = 0 never set viol, whatever their a1/a2 values.
- prop_ok (combinational) = !out_valid | (o1 == o2) | taint_out | viol.
- fail_cnt increments on each posedge where prop_ok == 0 and saturates at 2^CNT_W - 1 without wrapping.
- With the construction above, prop_ok == 1 always holds. fail_cnt is a checker hook for the bench and for formal tools, which target the assertion prop_ok == 1.
- Back-to-back samples: one result per cycle, in order. Bubbles (in_valid = 0) propagate as out_valid = 0.

Optional Feature:
- Macro: NI_SHORTCUT_EN.
- With the macro defined:
  - o2 = (taint_out | viol) ? copy-2 last-stage result : copy-1 last-stage result.
  - This is a shortcut tie that lets proof engines reuse copy 1's cone while the constraint holds.
  - prop_ok is unchanged.
- Without the macro: o2 is always copy 2's own result, and both copies are fully independent.

Test Plan:
- Reset, then DEPTH=2, in_valid=1, a1=a2=4'h6, b=4'h3, op=3 (ADD) → after 2 cycles: out_valid=1, o1=o2=4'h9, prop_ok=1, viol=0.
- ADD wrap: a1=a2=4'hF, b=4'h2, op=3 → o1=o2=4'h1 after 2 cycles; no carry is visible.
- Violation: a1=4'h5, a2=4'hA, b=4'hF, op=0 (AND), in_valid=1.
  - Next cycle: viol=1.
  - After 2 cycles without the macro: o1=4'h5, o2=4'hA, prop_ok=1, fail_cnt=0.
  - With NI_SHORTCUT_EN: o2=4'hA, because the tie is released once taint_out or viol is set.
- Bubble: in_valid=0 with a1=4'h1, a2=4'h2 → viol stays 0 and out_valid=0 two cycles later.
- Back-to-back: four valid samples, ops 0,1,2,3 with a=4'hC, b=4'hA → outputs 8, E, 6, 6 on four consecutive cycles, in order.
- Mid-flight reset: pulse rst_n low with two samples in the pipe → o1=o2=0 and out_valid=0 immediately, viol=0, and no stale outputs after release.
